// File: rtl/vec_add_sched_pkg.sv
// vec_add_sched_pkg: shared types and helpers for the vec_add_sched slice.
//   STAT_W     width of the optional per-requester grant counters
//   lane_vec_t default-shaped lane vector (DEF_N lanes of DEF_W bits); modules
//              with other W/N build the same shape locally from their params
//   id_w()     requester-id width, clog2(max(nreq,2))
package vec_add_sched_pkg;

    localparam int STAT_W = 16;
    localparam int DEF_W  = 8;
    localparam int DEF_N  = 4;

    typedef logic [DEF_N-1:0][DEF_W-1:0] lane_vec_t;

    function automatic int id_w(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/sched_rsp_fifo.sv
// sched_rsp_fifo: generic registered (non fall-through) FIFO.
//   clk, rst_n  clock, asynchronous active-low reset
//   push/push_data  write an entry (ignored when full)
//   pop             remove the head entry (ignored when empty)
//   empty, count    status; head is the oldest entry, zero when empty
module sched_rsp_fifo #(
    parameter int  DEPTH = 3,
    parameter type T     = logic
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    output logic                         empty,
    output T                             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (int'(count) == DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is only observable through head, which is masked while empty.
    assign head = empty ? '0 : mem[rd_ptr];

    // NOTE: the data array has no reset; every entry is written before it can
    // be read, so resetting it would only add reset fan-out to plain storage.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (int'(wr_ptr) == DEPTH-1) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (int'(rd_ptr) == DEPTH-1) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vec_add_sched.sv
// vec_add_sched: round-robin scheduler sharing one registered N-lane adder
// between NREQ requesters, with credit-limited issue into a response FIFO.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready is one-hot grant)
//   req_a, req_b          operand vectors per requester
//   dp_a, dp_b, dp_reset  drive the external adder (dp_reset is synchronous)
//   dp_y                  adder result, LAT cycles after its inputs
//   rsp_valid/rsp_ready   response handshake; rsp_id, rsp_y carry the result
// Optional build macro VEC_ADD_SCHED_STATS_EN adds stat_clr and stat_grants
// (saturating 16-bit per-requester grant counters).
module vec_add_sched
    import vec_add_sched_pkg::*;
#(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int NREQ = 2,
    parameter int LAT  = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NREQ-1:0]                   req_valid,
    output logic [NREQ-1:0]                   req_ready,
    input  logic [NREQ-1:0][N-1:0][W-1:0]     req_a,
    input  logic [NREQ-1:0][N-1:0][W-1:0]     req_b,
    output logic [N-1:0][W-1:0]               dp_a,
    output logic [N-1:0][W-1:0]               dp_b,
    output logic                              dp_reset,
    input  logic [N-1:0][W-1:0]               dp_y,
`ifdef VEC_ADD_SCHED_STATS_EN
    input  logic                              stat_clr,
    output logic [NREQ-1:0][STAT_W-1:0]       stat_grants,
`endif
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [id_w(NREQ)-1:0]             rsp_id,
    output logic [N-1:0][W-1:0]               rsp_y
);

    localparam int D   = LAT + 2;
    localparam int IDW = id_w(NREQ);
    localparam int CW  = $clog2(D + 1);

    typedef logic [N-1:0][W-1:0] vec_t;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } trk_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        vec_t           y;
    } rsp_t;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  scan_idx;
    logic            gnt_vld;
    logic [IDW-1:0]  gnt_id;
    logic            can_issue;
    trk_t [LAT-1:0]  pipe;
    trk_t            pipe_head;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    rsp_t            fifo_head;
    rsp_t            fifo_wdata;

    // Credit covers everything that may still land in the FIFO. A pop in the
    // same cycle is deliberately ignored; that keeps this path off the
    // consumer's rsp_ready while still allowing one issue per cycle.
    // rst_n gating holds the grant off while reset is asserted.
    assign can_issue = rst_n && ((int'(inflight) + int'(fifo_count)) < D);

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((int'(ptr) + k) % NREQ);
            if (!gnt_vld && req_valid[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = scan_idx;
            end
        end
        gnt_vld = gnt_vld && can_issue;
    end

    always_comb begin
        req_ready = '0;
        if (gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign dp_a = gnt_vld ? req_a[gnt_id] : '0;
    assign dp_b = gnt_vld ? req_b[gnt_id] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + 1'b1;
        end
    end

    // Adder reset is held one edge past rst_n release so the adder register
    // is cleared synchronously before the first possible grant result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_reset <= 1'b1;
        end else begin
            dp_reset <= 1'b0;
        end
    end

    // Tracking pipe: entry k is an issue k+1 cycles old, so the last entry
    // lines up with dp_y in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= '{vld: gnt_vld, id: gnt_id};
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign pipe_head = pipe[LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(pipe[i].vld);
        end
    end

    assign fifo_wdata = '{id: pipe_head.id, y: dp_y};

    sched_rsp_fifo #(
        .DEPTH (D),
        .T     (rsp_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_head.vld),
        .push_data (fifo_wdata),
        .pop       (rsp_valid && rsp_ready),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_id    = fifo_head.id;
    assign rsp_y     = fifo_head.y;

`ifdef VEC_ADD_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants <= '0;
        end else if (stat_clr) begin
            stat_grants <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && (stat_grants[i] != '1)) begin
                    stat_grants[i] <= stat_grants[i] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/vec_add_sched.md
# vec_add_sched

Round-robin scheduler that shares one registered N-lane vector adder between NREQ requesters. Each requester offers an operand pair with a valid/ready handshake. The scheduler selects one requester per cycle, drives the adder inputs, and tracks each issue through the adder's fixed latency. Results go into a small response FIFO tagged with the requester id, and issue is credit-limited so the adder, which cannot stall, never loses a result.

## Interface
- W, 8: lane width in bits.
- N, 4: lanes per vector.
- NREQ, 2: requester count (≥1).
- LAT, 1: adder latency in cycles, from inputs to its registered output.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i offers an operand pair.
- req_ready  out  NREQ  one-hot grant; a transfer happens when valid and ready are both high.
- req_a, req_b  in  [NREQ][N][W]  operand vectors per requester.
- dp_a, dp_b  out  [N][W]  adder operand inputs.
- dp_reset  out  1  synchronous active-high reset to the adder.
- dp_y  in  [N][W]  adder registered result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  clog2(max(NREQ,2))  requester that owns the response.
- rsp_y  out  [N][W]  result vector.

## Operation
- Arbiter: round-robin pointer `ptr`, which is 0 at reset.
  - Grant the first requester at or after `ptr` (mod NREQ) with req_valid=1, but only when `can_issue`.
  - After a grant to i, set ptr = (i+1) mod NREQ. If there is no grant, ptr holds.
- req_ready is combinational from req_valid, ptr and can_issue. It is all-zero when can_issue=0.
- dp_a/dp_b are muxed from the granted requester and are all-zero when there is no grant.
- Tracking: a LAT-deep shift pipe of {valid, id}. The head entry matches dp_y in the same cycle. A valid head pushes {id, dp_y} into the response FIFO.
- Response FIFO:
  - Depth D = LAT+2.
  - Registered, not fall-through.
  - rsp_valid = !empty; rsp_id/rsp_y come from the head entry.
  - A pop happens when rsp_valid && rsp_ready.
- Credit: can_issue = (inflight + count) < D.
  - inflight = number of valid pipe entries; count = FIFO occupancy.
  - A same-cycle pop is not credited. This is conservative and still sustains 1 issue/cycle when rsp_ready=1.
- Sums wrap modulo 2^W per lane. There is no carry between lanes and no saturation.
- A FIFO push when full is impossible by construction. Any implementation that can overflow is incorrect.
- dp_reset = registered copy of !reset. It is high during reset and for the first clock edge after reset deasserts.

## Timing
- Grant in cycle t → dp_y valid at t+LAT → FIFO entry written at edge end of t+LAT → rsp_valid in cycle t+LAT+1.
- Minimum request-to-response latency is LAT+1 cycles. Peak throughput is 1 response/cycle.
- With rsp_ready=0, at most D issues occur; after that, all req_ready stay 0 until a pop frees credit.
- Simultaneous push and pop on a non-empty FIFO keeps count unchanged.
- Values while reset=0:
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, dp_a=dp_b=0, dp_reset=1.
  - Pipe, FIFO and ptr are cleared.
- Reset asserted mid-operation discards all in-flight and buffered results. No response is produced for them.
- req_valid may drop without a grant; the scheduler imposes no stickiness requirement.

## Configuration
- VEC_ADD_SCHED_STATS_EN defined:
  - Adds output stat_grants [NREQ][16]: per-requester 16-bit grant counters.
  - Counters saturate at 0xFFFF and clear on reset.
  - Adds input stat_clr (1 bit): synchronous clear of all counters, with priority over increment.
- Undefined: stat_grants, stat_clr and the counters do not exist. All other behaviour is identical.

## Structure
- Package vec_add_sched_pkg holds:
  - lane vector typedef, parameterized by W and N;
  - id width function;
  - STAT_W=16 constant.
- Sub-module sched_rsp_fifo: generic registered FIFO with depth and data type as parameters, holding {id, y}.
- The arbiter, tracking pipe and credit logic live in the top level.

## Test plan
- Single request, NREQ=2, LAT=1: req 0 sends a={1,2,3,4}, b={10,20,30,40}, rsp_ready=1 → rsp_valid 2 cycles after grant, rsp_id=0, rsp_y={11,22,33,44}.
- Both requesters hold valid continuously → grants alternate 0,1,0,1; responses arrive in the same order, one per cycle.
- Wrap: lane a=0xFF, b=0x02 → lane result 0x01. Neighbouring lanes are unaffected.
- rsp_ready=0 with continuous requests → exactly 3 grants (D=3), then req_ready=0. Raising rsp_ready drains 3 responses in issue order, and issue resumes.
- Drive reset low while 2 results are in flight → all outputs return to their reset values immediately. After release, no stale responses appear and the first grant goes to requester 0.
- With STATS_EN: 70000 grants to requester 0 → stat_grants[0]=0xFFFF. Pulsing stat_clr → 0.
